// File: rtl/wb_reg_bridge_if.sv
// Bus bundle between a Wishbone master, the bridge and a simple register slave.
// The slave modport is the bridge's view of the bundle.
interface wb_reg_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [7:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        wbs_err_o;
    logic        reg_cs;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  reg_rdata, reg_ack,
        output wbs_dat_o, wbs_ack_o, wbs_err_o,
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output reg_rdata, reg_ack,
        input  wbs_dat_o, wbs_ack_o, wbs_err_o,
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be
    );
endinterface

// File: rtl/wb_reg_bridge.sv
// Wishbone slave to single-cycle-ack register bus bridge with a request timeout.
// Every output is a flop; a timed-out request terminates with wbs_err_o.
//
// state | meaning
// IDLE  | waiting for a fresh Wishbone strobe
// REQ   | reg_cs held, waiting for reg_ack or timeout
// RESP  | one-cycle ack/err termination, reg_cs low
module wb_reg_bridge #(
    parameter logic [15:0] TIMEOUT = 16'd255
) (
    input  logic            mclk,
    input  logic            reset_n,
    wb_reg_bridge_if.slave  bus,
    output logic [7:0]      tmo_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        cs_q, cs_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        start;
    logic        tmo_hit;

    // Blocking on our own ack/err keeps a held strobe from retriggering during termination.
    assign start   = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q & ~err_q;
    assign tmo_hit = (wait_q == TIMEOUT - 16'd1);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ: begin
                if (!bus.wbs_cyc_i)              state_d = IDLE;
                else if (bus.reg_ack || tmo_hit) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wait_d  = wait_q;
        cs_d    = cs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cs_d    = 1'b1;
                    wr_d    = bus.wbs_we_i;
                    addr_d  = bus.wbs_adr_i & 8'hFC;
                    wdata_d = bus.wbs_dat_i;
                    be_d    = bus.wbs_sel_i;
                    wait_d  = '0;
                end
            end
            REQ: begin
                // An abandoned cycle wins over a coincident ack; reg_ack beats the timeout.
                if (!bus.wbs_cyc_i) begin
                    cs_d = 1'b0;
                end else if (bus.reg_ack) begin
                    cs_d  = 1'b0;
                    ack_d = 1'b1;
                    dat_d = wr_q ? 32'd0 : bus.reg_rdata;
                end else if (tmo_hit) begin
                    cs_d  = 1'b0;
                    err_d = 1'b1;
                    dat_d = 32'd0;
                    if (tmo_q != 8'hFF) tmo_d = tmo_q + 8'd1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            RESP:    cs_d = 1'b0;
            default: cs_d = 1'b0;
        endcase
    end

    assign bus.reg_cs    = cs_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_be    = be_q;
    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_err_o = err_q;
    assign bus.wbs_dat_o = dat_q;
    assign tmo_cnt       = tmo_q;

endmodule

// File: doc/wb_reg_bridge.md
WB_REG_BRIDGE -- requirements
Module: wb_reg_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 16'd255, REQ-state cycles without reg_ack before error termination (legal range 2..65535).
REQ-002 mclk  input  1  single clock for all logic; rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 wbs_cyc_i  input  1  Wishbone cycle valid.
REQ-005 wbs_stb_i  input  1  Wishbone strobe.
REQ-006 wbs_we_i  input  1  1 = write, 0 = read.
REQ-007 wbs_adr_i  input  8  byte address.
REQ-008 wbs_dat_i  input  32  write data.
REQ-009 wbs_sel_i  input  4  byte lane selects.
REQ-010 wbs_dat_o  output  32  read data, valid with wbs_ack_o.
REQ-011 wbs_ack_o  output  1  single-cycle normal termination.
REQ-012 wbs_err_o  output  1  single-cycle timeout termination.
REQ-013 reg_cs  output  1  register-bus chip select.
REQ-014 reg_wr  output  1  register-bus write strobe.
REQ-015 reg_addr  output  8  register-bus byte address.
REQ-016 reg_wdata  output  32  register-bus write data.
REQ-017 reg_be  output  4  register-bus byte enables.
REQ-018 reg_rdata  input  32  register-bus read data, valid with reg_ack.
REQ-019 reg_ack  input  1  register-bus acknowledge, single-cycle pulse.
REQ-020 tmo_cnt  output  8  saturating count of timeout terminations.

Function
REQ-021 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-022 FSM states: IDLE, REQ, RESP.
REQ-023 IDLE -> REQ SHALL occur on wbs_cyc_i & wbs_stb_i & !wbs_ack_o & !wbs_err_o, capturing reg_wr=wbs_we_i, reg_addr={wbs_adr_i[7:2],2'b00}, reg_wdata=wbs_dat_i, reg_be=wbs_sel_i, and setting reg_cs=1.
REQ-024 In REQ, reg_cs and all captured reg_* fields SHALL remain stable.
REQ-025 REQ -> RESP SHALL occur on reg_ack=1, clearing reg_cs, loading wbs_dat_o=reg_rdata for reads or 0 for writes, and setting wbs_ack_o=1 for exactly one cycle.
REQ-026 A 16-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without reg_ack.
REQ-027 If the wait counter reaches TIMEOUT-1 without reg_ack, REQ -> RESP SHALL occur, clearing reg_cs, setting wbs_dat_o=0, pulsing wbs_err_o for one cycle, and incrementing tmo_cnt (saturating at 8'hFF).
REQ-028 If reg_ack and timeout occur in the same cycle, reg_ack SHALL win: ack, no error, no tmo_cnt increment.
REQ-029 RESP -> IDLE SHALL occur unconditionally after one cycle, guaranteeing reg_cs is low for at least one cycle between transactions.
REQ-030 In IDLE, a transaction SHALL start only on a strobe presented after termination (not during the ack/err cycle).
REQ-031 If wbs_cyc_i drops in REQ, the FSM SHALL return to IDLE next cycle with reg_cs=0, no wbs_ack_o/wbs_err_o, and no tmo_cnt change.
REQ-032 A reg_ack received in IDLE or RESP SHALL be ignored.
REQ-033 Latency with a slave acking one cycle after reg_cs: strobe sampled at edge N, reg_cs high after N, reg_ack sampled at N+2, wbs_ack_o high after N+2 (3 cycles strobe to ack).

Reset
REQ-034 On reset_n=0, asynchronously: state=IDLE, reg_cs=0, reg_wr=0, reg_addr=0, reg_wdata=0, reg_be=0, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, tmo_cnt=0, wait counter=0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no termination pulse after release.

Verification
REQ-036 Write adr 0x20, dat 0x0000_00A5, sel 4'hF, slave acks 1 cycle after reg_cs -> reg_cs=1/reg_wr=1/reg_addr=0x20/reg_be=F for exactly 2 cycles; wbs_ack_o single pulse 3 cycles after strobe; wbs_dat_o=0.
REQ-037 Read adr 0x24 from config slave out of reset -> wbs_dat_o=32'h4C66_8354 with wbs_ack_o.
REQ-038 TIMEOUT=16, slave never acks -> reg_cs high 16 cycles, then wbs_err_o pulse, wbs_dat_o=0, tmo_cnt=1; 256 such timeouts -> tmo_cnt=8'hFF.
REQ-039 wbs_cyc_i dropped 2 cycles into REQ, late reg_ack injected next cycle -> reg_cs low next cycle, no ack/err.
REQ-040 Back-to-back: strobe held, new adr 0x28 presented after first ack -> reg_cs low at least 1 cycle between, second read returns 32'h1603_2022.
REQ-041 reset_n pulsed low while in REQ -> all outputs 0 immediately; no wbs_ack_o after release.
